corelet_ctrl: RTL
=================

// Module: corelet_ctrl
// PURPOSE
//  Job sequencer for the corelet (L0 -> MAC array -> OFIFO -> SFP). For num_tiles passes it
//  loads one weight tile, streams act_len activations, drains the OFIFO into psum memory,
//  then replays psum memory through SFP accumulate. Drives the 35-bit corelet inst word
//  plus activation/weight memory (xmem) and psum memory (pmem) controls.
// PARAMETERS
//  row      8   MAC array rows (L0 width)
//  col      8   MAC array cols; weight words per tile
//  len_bw   8   width of act_len
//  addr_bw  11  xmem/pmem address width
//  l0_depth 64  L0 entries; act_len must be <= l0_depth-1
// PORTS
//  clk         in  1        clock
//  reset       in  1        synchronous, active-high
//  start       in  1        job start; sampled only in IDLE
//  mode        in  1        MAC mode; latched at start, driven on inst[34]
//  num_tiles   in  4        tile passes, 1..15 (0 treated as 1)
//  act_len     in  len_bw   activations per tile, 1..l0_depth-1
//  l0_full     in  1        from L0
//  ofifo_valid in  1        from corelet
//  inst        out 35       corelet instruction word
//  xmem_cen    out 1        xmem read enable, active-low
//  xmem_addr   out addr_bw  xmem read address
//  pmem_cen    out 1        pmem read enable, active-low
//  pmem_wen    out 1        pmem write enable, active-low
//  pmem_addr   out addr_bw  pmem address
//  sfp_clr     out 1        1-cycle pulse: SFP output for one row complete
//  busy        out 1        high in any state except IDLE
//  done        out 1        1-cycle pulse on DONE->IDLE
//  err         out 1        sticky: l0_full seen while inst[2]=1; cleared only by reset
// BEHAVIOUR
//  inst map: [0] load, [1] execute, [2] l0_wr, [3] l0_rd, [6] ofifo_rd, [33] acc,
//   [34] mode_q; all other bits 0. Everything registered.
//  Reset: FSM=IDLE, counters 0, inst=0, cen/wen=1, addrs=0, busy/done/sfp_clr/err=0.
//   Reset wins over any in-flight job.
//  xmem read latency 1: inst[2] is xmem read-issue delayed one cycle; xmem_addr is a single
//   running counter from 0 (per tile: col weight words, then act_len activations).
//  FSM (t = tile idx, k = inner count):
//   IDLE: start -> latch mode/num_tiles/act_len, t=0 -> W_FILL.
//   W_FILL: issue col xmem reads -> W_LOAD once last L0 write has occurred.
//   W_LOAD: inst[3]=inst[0]=1 for col cycles -> W_SETTLE.
//   W_SETTLE: idle row+col cycles -> A_FILL.
//   A_FILL: issue act_len reads -> A_EXEC after last L0 write.
//   A_EXEC: inst[3]=inst[1]=1 for act_len cycles -> DRAIN.
//   DRAIN: inst[6]=ofifo_valid && k<act_len; each read -> pmem write next cycle,
//    addr t*act_len+k. After act_len writes: t<num_tiles-1 -> t++, W_FILL; else ACC.
//   ACC: for o=0..act_len-1, for u=0..num_tiles-1: pmem read addr u*act_len+o;
//    inst[33]=1 the cycle after each read; sfp_clr one cycle after last acc of each o.
//    After final sfp_clr -> DONE.
//   DONE: done=1 one cycle -> IDLE.
//  start outside IDLE ignored. Address arithmetic mod 2^addr_bw (no overflow check).
//  pmem read and write never in the same cycle; inst[0] and inst[1] never both 1.
// TESTING
//  1. Reset mid-A_EXEC -> next cycle inst=0, busy=0, cen/wen=1; new start runs cleanly.
//  2. num_tiles=1, act_len=4: xmem_addr 0..11; inst[0] exactly 8 cycles; inst[1] exactly
//     4 cycles; 4 pmem writes addr 0..3; 4 acc pulses, 4 sfp_clr; done once.
//  3. num_tiles=3, act_len=2: pmem writes 0..5; ACC read order 0,2,4,1,3,5; 6 acc, 2 sfp_clr.
//  4. ofifo_valid toggling 1/0 in DRAIN -> inst[6] only with ofifo_valid; exactly act_len
//     writes, addrs contiguous.
//  5. start held high through a job and after done -> exactly one job per IDLE entry.
//  6. Force l0_full=1 during A_FILL -> err rises next cycle and stays 1 until reset.

Source files
------------

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: job sequencer for the corelet datapath (L0 -> MAC array -> OFIFO -> SFP).
// For each of num_tiles passes it fetches one weight tile from xmem into L0, loads it into
// the MAC array, fetches and executes act_len activations, drains the OFIFO into psum memory,
// and finally replays psum memory through the SFP accumulator, one output row at a time.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset (wins over any running job)
//   start           job start, sampled only while idle
//   mode            MAC mode, latched at start and driven on inst[34]
//   num_tiles       tile passes (0 is treated as 1)
//   act_len         activations per tile (1..l0_depth-1)
//   l0_full         L0 full flag; an L0 write while full raises err
//   ofifo_valid     OFIFO has data
//   inst            35-bit corelet instruction word
//   xmem_cen/addr   activation/weight memory read enable (active-low) and address
//   pmem_cen/wen    psum memory read / write enables (active-low)
//   pmem_addr       psum memory address
//   sfp_clr         one-cycle pulse when the SFP output of a row is complete
//   busy            high whenever a job is in progress
//   done            one-cycle pulse as the sequencer returns to idle
//   err             sticky L0 overflow flag, cleared only by reset
module corelet_ctrl #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int len_bw   = 8,
  parameter int addr_bw  = 11,
  parameter int l0_depth = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [3:0]         num_tiles,
  input  logic [len_bw-1:0]  act_len,
  input  logic               l0_full,
  input  logic               ofifo_valid,
  output logic [34:0]        inst,
  output logic               xmem_cen,
  output logic [addr_bw-1:0] xmem_addr,
  output logic               pmem_cen,
  output logic               pmem_wen,
  output logic [addr_bw-1:0] pmem_addr,
  output logic               sfp_clr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CW = len_bw + 2;
  localparam logic [CW-1:0]     COL_C    = CW'(col);
  localparam logic [CW-1:0]     SETTLE_C = CW'(row + col - 1);
  localparam logic [len_bw-1:0] LEN_MAX  = len_bw'(l0_depth - 1);

  typedef enum logic [3:0] {
    IDLE, W_FILL, W_LOAD, W_SETTLE, A_FILL, A_EXEC, DRAIN, ACC, DONE
  } state_t;

  state_t state, state_n;

  logic               mode_q, mode_n;
  logic [3:0]         ntiles, ntiles_n;
  logic [len_bw-1:0]  alen, alen_n;
  logic [3:0]         t, t_n;
  logic [CW-1:0]      k, k_n;          // inner count: reads issued / cycles spent
  logic [CW-1:0]      j, j_n;          // pmem writes issued in DRAIN
  logic [addr_bw-1:0] pbase, pbase_n;  // t*act_len, kept as a running sum
  logic [CW-1:0]      o, o_n;          // ACC output row
  logic [3:0]         u, u_n;          // ACC tile within the row
  logic [addr_bw-1:0] rptr, rptr_n;    // u*act_len+o, kept as a running sum
  logic               rd_last, rd_last_n;   // current pmem read is the row's last tile
  logic               acc_last, acc_last_n; // current acc is the row's last tile

  logic [34:0]        inst_n;
  logic               xmem_cen_n, pmem_cen_n, pmem_wen_n;
  logic [addr_bw-1:0] xmem_addr_n, pmem_addr_n;
  logic               sfp_clr_n, busy_n, done_n, err_n;

  logic [3:0]         nt_in;
  logic [len_bw-1:0]  al_in;
  logic [CW-1:0]      alen_ext;

  // Degenerate job sizes are coerced: zero tiles runs one, zero length would never
  // reach DONE, and a length beyond L0 capacity would overrun it.
  assign nt_in    = (num_tiles == 4'd0) ? 4'd1 : num_tiles;
  assign al_in    = (act_len == '0) ? len_bw'(1) :
                    ((act_len > LEN_MAX) ? LEN_MAX : act_len);
  assign alen_ext = CW'(alen);

  always_comb begin
    state_n    = state;
    mode_n     = mode_q;
    ntiles_n   = ntiles;
    alen_n     = alen;
    t_n        = t;
    k_n        = k;
    j_n        = j;
    pbase_n    = pbase;
    o_n        = o;
    u_n        = u;
    rptr_n     = rptr;
    rd_last_n  = 1'b0;
    acc_last_n = rd_last;

    inst_n      = '0;
    inst_n[34]  = mode_q;
    // xmem and pmem both have one cycle of read latency: the L0 write and the SFP
    // accumulate follow the corresponding read issue by exactly one cycle.
    inst_n[2]   = ~xmem_cen;
    inst_n[33]  = ~pmem_cen;
    xmem_cen_n  = 1'b1;
    xmem_addr_n = xmem_cen ? xmem_addr : xmem_addr + addr_bw'(1);
    pmem_cen_n  = 1'b1;
    pmem_wen_n  = 1'b1;
    pmem_addr_n = pmem_addr;
    sfp_clr_n   = acc_last;
    done_n      = 1'b0;
    err_n       = err | (l0_full & inst[2]);

    case (state)
      IDLE: begin
        if (start) begin
          mode_n      = mode;
          inst_n[34]  = mode;
          ntiles_n    = nt_in;
          alen_n      = al_in;
          t_n         = '0;
          k_n         = '0;
          j_n         = '0;
          pbase_n     = '0;
          xmem_addr_n = '0;
          state_n     = W_FILL;
        end
      end
      W_FILL: begin
        if (k < COL_C) begin
          xmem_cen_n = 1'b0;
          k_n        = k + CW'(1);
        end else if (xmem_cen && inst[2]) begin
          // last weight word is being written into L0 this cycle
          k_n     = '0;
          state_n = W_LOAD;
        end
      end
      W_LOAD: begin
        if (k < COL_C) begin
          inst_n[3] = 1'b1;
          inst_n[0] = 1'b1;
          k_n       = k + CW'(1);
        end else begin
          k_n     = '0;
          state_n = W_SETTLE;
        end
      end
      W_SETTLE: begin
        if (k == SETTLE_C) begin
          k_n     = '0;
          state_n = A_FILL;
        end else begin
          k_n = k + CW'(1);
        end
      end
      A_FILL: begin
        if (k < alen_ext) begin
          xmem_cen_n = 1'b0;
          k_n        = k + CW'(1);
        end else if (xmem_cen && inst[2]) begin
          k_n     = '0;
          state_n = A_EXEC;
        end
      end
      A_EXEC: begin
        if (k < alen_ext) begin
          inst_n[3] = 1'b1;
          inst_n[1] = 1'b1;
          k_n       = k + CW'(1);
        end else begin
          k_n     = '0;
          j_n     = '0;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (ofifo_valid && (k < alen_ext)) begin
          inst_n[6] = 1'b1;
          k_n       = k + CW'(1);
        end
        if (inst[6]) begin
          pmem_wen_n  = 1'b0;
          pmem_addr_n = pbase + addr_bw'(j);
          j_n         = j + CW'(1);
        end
        // the final write is on the bus this cycle and no read is outstanding
        if (!pmem_wen && (j == alen_ext)) begin
          k_n = '0;
          j_n = '0;
          if (t < ntiles - 4'd1) begin
            t_n     = t + 4'd1;
            pbase_n = pbase + addr_bw'(alen);
            state_n = W_FILL;
          end else begin
            o_n     = '0;
            u_n     = '0;
            rptr_n  = '0;
            state_n = ACC;
          end
        end
      end
      ACC: begin
        if (o < alen_ext) begin
          pmem_cen_n  = 1'b0;
          pmem_addr_n = rptr;
          if (u == ntiles - 4'd1) begin
            rd_last_n = 1'b1;
            u_n       = '0;
            o_n       = o + CW'(1);
            rptr_n    = addr_bw'(o + CW'(1));
          end else begin
            u_n    = u + 4'd1;
            rptr_n = rptr + addr_bw'(alen);
          end
        end else if (pmem_cen && !acc_last && sfp_clr) begin
          // read/acc pipeline empty and the final row's sfp_clr is out
          state_n = DONE;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      ntiles    <= '0;
      alen      <= '0;
      t         <= '0;
      k         <= '0;
      j         <= '0;
      pbase     <= '0;
      o         <= '0;
      u         <= '0;
      rptr      <= '0;
      rd_last   <= 1'b0;
      acc_last  <= 1'b0;
      inst      <= '0;
      xmem_cen  <= 1'b1;
      xmem_addr <= '0;
      pmem_cen  <= 1'b1;
      pmem_wen  <= 1'b1;
      pmem_addr <= '0;
      sfp_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      mode_q    <= mode_n;
      ntiles    <= ntiles_n;
      alen      <= alen_n;
      t         <= t_n;
      k         <= k_n;
      j         <= j_n;
      pbase     <= pbase_n;
      o         <= o_n;
      u         <= u_n;
      rptr      <= rptr_n;
      rd_last   <= rd_last_n;
      acc_last  <= acc_last_n;
      inst      <= inst_n;
      xmem_cen  <= xmem_cen_n;
      xmem_addr <= xmem_addr_n;
      pmem_cen  <= pmem_cen_n;
      pmem_wen  <= pmem_wen_n;
      pmem_addr <= pmem_addr_n;
      sfp_clr   <= sfp_clr_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule
